keystream_fifo: RTL and testbench

Port-mapped byte FIFO between the two PicoBlaze cores of the Vernam design. The random-number core (producer) writes keystream bytes into it with OUTPUT instructions. The cipher core (consumer) pulls them one at a time with INPUT instructions and XORs them with plaintext. It decouples the two cores' program timing, replacing direct core-to-core port wiring, and reports fill level and sticky error flags to both sides through a status port.

---
 rtl/keystream_fifo.sv | 101 ++++++++++
 tb/tb_keystream_fifo.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/keystream_fifo.sv
// Port-mapped keystream byte FIFO between the producer (RNG) and consumer (cipher) PicoBlaze cores.
// Every read port is registered from state and port_id sampled at the previous edge.
module keystream_fifo #(
  parameter int          DEPTH       = 16,
  parameter logic [7:0]  PUSH_PORT   = 8'h01,
  parameter logic [7:0]  DATA_PORT   = 8'h02,
  parameter logic [7:0]  STATUS_PORT = 8'h03
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] prod_port_id,
  input  logic [7:0] prod_out_port,
  input  logic       prod_write_strobe,
  output logic [7:0] prod_in_port,
  input  logic [7:0] cons_port_id,
  input  logic [7:0] cons_out_port,
  input  logic       cons_write_strobe,
  input  logic       cons_read_strobe,
  output logic [7:0] cons_in_port
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          underflow;
  logic          overflow;

  logic       push_fire, pop_fire, push_ok, pop_ok;
  logic       empty, full, clear_sel;
  logic       underflow_set, overflow_set;
  logic [7:0] status;
  logic [7:0] head;
  logic       unused_clear_bits;

  assign empty     = (count == '0);
  assign full      = (count == FULL_CNT);
  assign push_fire = prod_write_strobe && (prod_port_id == PUSH_PORT);
  assign pop_fire  = cons_read_strobe && (cons_port_id == DATA_PORT);
  assign pop_ok    = pop_fire && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok   = push_fire && (!full || pop_ok);
  assign clear_sel = cons_write_strobe && (cons_port_id == STATUS_PORT);

  assign underflow_set = pop_fire && empty;
  assign overflow_set  = push_fire && !push_ok;

  assign status = {underflow, overflow, full, 5'(count)};
  assign head   = empty ? 8'h00 : mem[rd_ptr];

  assign unused_clear_bits = &{1'b0, cons_out_port[5:0]};

  always_comb begin
    count_next = count;
    unique case ({push_ok, pop_ok})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // Storage is data only; its contents are unobservable while empty, so it is not reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= prod_out_port;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      underflow    <= 1'b0;
      overflow     <= 1'b0;
      prod_in_port <= 8'h00;
      cons_in_port <= 8'h00;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;

      // A new error event outranks a clear landing in the same cycle.
      underflow <= underflow_set | (underflow & ~(clear_sel & cons_out_port[7]));
      overflow  <= overflow_set  | (overflow  & ~(clear_sel & cons_out_port[6]));

      if (cons_port_id == DATA_PORT)
        cons_in_port <= head;
      else if (cons_port_id == STATUS_PORT)
        cons_in_port <= status;
      else
        cons_in_port <= 8'h00;

      prod_in_port <= (prod_port_id == STATUS_PORT) ? status : 8'h00;
    end
  end

endmodule

// File: tb/tb_keystream_fifo.sv
// Directed plus randomized bench for keystream_fifo, checked against a queue-based reference model.
module tb_keystream_fifo;

  localparam int         DEPTH = 16;
  localparam logic [7:0] PUSH  = 8'h01;
  localparam logic [7:0] DATA  = 8'h02;
  localparam logic [7:0] STAT  = 8'h03;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] prod_port_id, prod_out_port, prod_in_port;
  logic       prod_write_strobe;
  logic [7:0] cons_port_id, cons_out_port, cons_in_port;
  logic       cons_write_strobe, cons_read_strobe;

  int total = 0;
  int bad   = 0;

  logic [7:0] q[$];
  logic       m_unf, m_ovf;
  logic [7:0] cap;

  always #5 clk = ~clk;

  keystream_fifo #(
    .DEPTH(DEPTH), .PUSH_PORT(PUSH), .DATA_PORT(DATA), .STATUS_PORT(STAT)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .prod_port_id(prod_port_id),
    .prod_out_port(prod_out_port),
    .prod_write_strobe(prod_write_strobe),
    .prod_in_port(prod_in_port),
    .cons_port_id(cons_port_id),
    .cons_out_port(cons_out_port),
    .cons_write_strobe(cons_write_strobe),
    .cons_read_strobe(cons_read_strobe),
    .cons_in_port(cons_in_port)
  );

  function automatic logic [7:0] m_status();
    return {m_unf, m_ovf, (q.size() == DEPTH), 5'(q.size())};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply inputs, predict outputs from pre-edge model state, advance model, check.
  task automatic step(input logic pw, input logic [7:0] pid, input logic [7:0] pd,
                      input logic cr, input logic [7:0] cid, input logic cw, input logic [7:0] co);
    logic [7:0] ec, ep, st;
    logic us, os;
    prod_write_strobe = pw;
    prod_port_id      = pid;
    prod_out_port     = pd;
    cons_read_strobe  = cr;
    cons_port_id      = cid;
    cons_write_strobe = cw;
    cons_out_port     = co;
    cap = cons_in_port;
    us = 1'b0;
    os = 1'b0;
    st = m_status();
    if (!reset_n) begin
      ec = 8'h00;
      ep = 8'h00;
      q.delete();
      m_unf = 1'b0;
      m_ovf = 1'b0;
    end else begin
      ec = (cid == DATA) ? ((q.size() > 0) ? q[0] : 8'h00) : (cid == STAT) ? st : 8'h00;
      ep = (pid == STAT) ? st : 8'h00;
      if (cr && cid == DATA) begin
        if (q.size() > 0) void'(q.pop_front());
        else us = 1'b1;
      end
      if (pw && pid == PUSH) begin
        if (q.size() < DEPTH) q.push_back(pd);
        else os = 1'b1;
      end
      if (cw && cid == STAT) begin
        if (co[7]) m_unf = 1'b0;
        if (co[6]) m_ovf = 1'b0;
      end
      m_unf = m_unf | us;
      m_ovf = m_ovf | os;
    end
    @(posedge clk);
    #1;
    chk("cons_in_port", cons_in_port, ec);
    chk("prod_in_port", prod_in_port, ep);
  endtask

  task automatic push(input logic [7:0] d);
    step(1'b1, PUSH, d, 1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  // Park port_id on DATA for one edge, then pop; the core captures the byte presented by the park.
  task automatic pop_chk(input string tag, input logic [7:0] exp);
    step(1'b0, 8'h00, 8'h00, 1'b0, DATA, 1'b0, 8'h00);
    step(1'b0, 8'h00, 8'h00, 1'b1, DATA, 1'b0, 8'h00);
    chk(tag, cap, exp);
  endtask

  task automatic rd_status(input string tag, input logic [7:0] exp);
    step(1'b0, STAT, 8'h00, 1'b0, STAT, 1'b0, 8'h00);
    chk(tag, cons_in_port, exp);
    chk(tag, prod_in_port, exp);
  endtask

  task automatic clear(input logic [7:0] mask);
    step(1'b0, 8'h00, 8'h00, 1'b0, STAT, 1'b1, mask);
  endtask

  initial begin
    logic [7:0] arr [DEPTH];
    logic [7:0] base, x;
    logic [7:0] ports [5];
    ports[0] = 8'h00; ports[1] = PUSH; ports[2] = DATA; ports[3] = STAT; ports[4] = 8'h7F;
    m_unf = 1'b0;
    m_ovf = 1'b0;
    prod_port_id = 8'h00; prod_out_port = 8'h00; prod_write_strobe = 1'b0;
    cons_port_id = 8'h00; cons_out_port = 8'h00; cons_write_strobe = 1'b0; cons_read_strobe = 1'b0;

    // reset with strobes active
    reset_n = 1'b0;
    step(1'b1, PUSH, 8'h99, 1'b1, DATA, 1'b0, 8'h00);
    step(1'b1, STAT, 8'h99, 1'b1, STAT, 1'b1, 8'hFF);
    chk("reset_cons", cons_in_port, 8'h00);
    chk("reset_prod", prod_in_port, 8'h00);
    reset_n = 1'b1;
    rd_status("reset_status", 8'h00);

    // ordering
    push(8'hA5); push(8'h3C); push(8'hFF);
    rd_status("order_status3", 8'h03);
    pop_chk("order_pop0", 8'hA5);
    pop_chk("order_pop1", 8'h3C);
    pop_chk("order_pop2", 8'hFF);
    rd_status("order_status0", 8'h00);

    // full / overflow
    for (int i = 0; i <= 16; i++) push(8'(i));
    rd_status("full_status", 8'h70);
    for (int i = 0; i < 16; i++) pop_chk("full_drain", 8'(i));
    rd_status("drained_status", 8'h40);
    clear(8'h40);
    rd_status("ovf_cleared", 8'h00);

    // underflow and clear
    pop_chk("uf_capture", 8'h00);
    rd_status("uf_status", 8'h80);
    clear(8'h80);
    rd_status("uf_cleared", 8'h00);

    // fill with random bytes, then overflow and clear in the same cycle: set wins
    for (int i = 0; i < DEPTH; i++) begin
      arr[i] = 8'($urandom);
      push(arr[i]);
    end
    rd_status("refill_status", 8'h30);
    step(1'b1, PUSH, 8'hEE, 1'b0, STAT, 1'b1, 8'h40);
    rd_status("set_wins_status", 8'h70);
    clear(8'h40);
    rd_status("set_wins_cleared", 8'h30);

    // simultaneous push and pop while full
    step(1'b0, 8'h00, 8'h00, 1'b0, DATA, 1'b0, 8'h00);
    step(1'b1, PUSH, 8'h55, 1'b1, DATA, 1'b0, 8'h00);
    chk("sim_full_capture", cap, arr[0]);
    rd_status("sim_full_status", 8'h30);
    for (int i = 1; i < DEPTH; i++) pop_chk("sim_full_drain", arr[i]);
    pop_chk("sim_full_last", 8'h55);
    rd_status("sim_full_empty", 8'h00);

    // simultaneous push and pop while empty
    x = 8'($urandom);
    step(1'b0, 8'h00, 8'h00, 1'b0, DATA, 1'b0, 8'h00);
    step(1'b1, PUSH, x, 1'b1, DATA, 1'b0, 8'h00);
    chk("sim_empty_capture", cap, 8'h00);
    rd_status("sim_empty_status", 8'h81);
    pop_chk("sim_empty_byte", x);
    clear(8'hC0);
    rd_status("sim_empty_cleared", 8'h00);

    // wrap-around with interleaved push/pop pairs
    base = 8'($urandom);
    for (int i = 0; i < 40; i++) begin
      push(base + 8'(i));
      rd_status("wrap_count", 8'h01);
      pop_chk("wrap_pop", base + 8'(i));
    end
    rd_status("wrap_end", 8'h00);

    // randomized traffic, including a mid-run reset
    for (int i = 0; i < 600; i++) begin
      if (i == 300) reset_n = 1'b0;
      step(1'($urandom_range(0, 1)), ports[$urandom_range(0, 4)], 8'($urandom),
           ($urandom_range(0, 2) == 0), ports[$urandom_range(0, 4)],
           ($urandom_range(0, 7) == 0), 8'($urandom));
      reset_n = 1'b1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
